segmented_register: RTL and testbench

- General N-segment successor to the two-half loadable register used by the SAP2 datapath (MAR, PC, operand latches).
- Each segment loads in parallel from any bus segment (this covers replicating the low byte into upper segments).
- Adds a sequential segment-by-segment loader, so a wide register can be filled from a narrow bus over several cycles.
- Adds increment/decrement with wrap detection, so PC/SP-style registers reuse the block.

---
 rtl/segmented_register_if.sv | 36 +++
 rtl/segmented_register.sv | 131 +++++++++++++
 tb/tb_segmented_register.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/segmented_register_if.sv
// Bus bundle for segmented_register: parallel load, sequential load, inc/dec controls and status.
// The testbench or datapath drives through master; the register consumes through slave.
interface segmented_register_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEGS  = 2
);
    localparam int unsigned SEG_W = WIDTH / SEGS;
    localparam int unsigned SEL_W = (SEGS > 1) ? $clog2(SEGS) : 1;

    logic [SEGS-1:0]       i_load_enable;
    logic [SEGS*SEL_W-1:0] i_load_src_sel;
    logic [WIDTH-1:0]      i_load_data;
    logic                  i_inc;
    logic                  i_dec;
    logic                  i_seq_start;
    logic                  i_seq_valid;
    logic [SEG_W-1:0]      i_seq_data;
    logic [WIDTH-1:0]      o_data;
    logic                  o_seq_busy;
    logic                  o_seq_done;
    logic                  o_wrap;

    modport master (
        output i_load_enable, i_load_src_sel, i_load_data,
        output i_inc, i_dec,
        output i_seq_start, i_seq_valid, i_seq_data,
        input  o_data, o_seq_busy, o_seq_done, o_wrap
    );

    modport slave (
        input  i_load_enable, i_load_src_sel, i_load_data,
        input  i_inc, i_dec,
        input  i_seq_start, i_seq_valid, i_seq_data,
        output o_data, o_seq_busy, o_seq_done, o_wrap
    );
endinterface

// File: rtl/segmented_register.sv
// N-segment loadable register: per-segment parallel load with source select, LSB-first
// sequential segment loader, and whole-register increment/decrement with a registered wrap flag.
module segmented_register #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEGS  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    segmented_register_if.slave bus
);
    localparam int unsigned SEG_W = WIDTH / SEGS;
    localparam int unsigned SEL_W = (SEGS > 1) ? $clog2(SEGS) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_seq_busy;
    logic             w_seq_busy_nxt;
    logic             r_seq_done;
    logic             w_seq_done_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;

    logic [WIDTH-1:0] w_par_data;
    logic             w_seq_wr;
    logic             w_any_wr;

    assign w_seq_wr = (r_state == ST_LOAD) && bus.i_seq_valid;
    assign w_any_wr = w_seq_wr || (|bus.i_load_enable);

    // Per-segment source mux; an out-of-range select falls back to the segment's own lane.
    always_comb begin
        w_par_data = bus.i_load_data;
        for (int k = 0; k < int'(SEGS); k++) begin
            for (int j = 0; j < int'(SEGS); j++) begin
                if (bus.i_load_src_sel[k*SEL_W +: SEL_W] == SEL_W'(j)) begin
                    w_par_data[k*SEG_W +: SEG_W] = bus.i_load_data[j*SEG_W +: SEG_W];
                end
            end
        end
    end

    // Next-state: data path, inc/dec and loader FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_data_nxt     = r_data;
        w_seq_busy_nxt = r_seq_busy;
        w_seq_done_nxt = 1'b0;
        w_wrap_nxt     = 1'b0;

        for (int k = 0; k < int'(SEGS); k++) begin
            if (bus.i_load_enable[k]) begin
                w_data_nxt[k*SEG_W +: SEG_W] = w_par_data[k*SEG_W +: SEG_W];
            end else if (w_seq_wr && (r_ptr == SEL_W'(k))) begin
                w_data_nxt[k*SEG_W +: SEG_W] = bus.i_seq_data;
            end
        end

        // Any write that cycle takes precedence; inc and dec together cancel.
        if (!w_any_wr && (bus.i_inc ^ bus.i_dec)) begin
            if (bus.i_inc) begin
                w_data_nxt = r_data + WIDTH'(1);
                w_wrap_nxt = &r_data;
            end else begin
                w_data_nxt = r_data - WIDTH'(1);
                w_wrap_nxt = ~|r_data;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (bus.i_seq_start) begin
                    w_state_nxt    = ST_LOAD;
                    w_ptr_nxt      = '0;
                    w_seq_busy_nxt = 1'b1;
                end
            end
            ST_LOAD: begin
                // A beat advances the pointer even when a parallel load overrides its segment.
                if (bus.i_seq_valid) begin
                    if (r_ptr == SEL_W'(SEGS - 1)) begin
                        w_state_nxt    = ST_IDLE;
                        w_ptr_nxt      = '0;
                        w_seq_busy_nxt = 1'b0;
                        w_seq_done_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt = r_ptr + SEL_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_ptr_nxt      = '0;
                w_seq_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_data     <= '0;
            r_seq_busy <= 1'b0;
            r_seq_done <= 1'b0;
            r_wrap     <= 1'b0;
        end else if (clk_en) begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_data     <= w_data_nxt;
            r_seq_busy <= w_seq_busy_nxt;
            r_seq_done <= w_seq_done_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end

    assign bus.o_data     = r_data;
    assign bus.o_seq_busy = r_seq_busy;
    assign bus.o_seq_done = r_seq_done;
    assign bus.o_wrap     = r_wrap;
endmodule

// File: tb/tb_segmented_register.sv
// Directed self-checking bench for segmented_register across three geometries
// (16/2, 12/3 for out-of-range selects, 16/4 for the sequential loader and inc/dec).
module tb_segmented_register;
    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt;
    int   done_cnt;

    always #5 clk = ~clk;

    segmented_register_if #(.WIDTH(16), .SEGS(2)) if2 ();
    segmented_register_if #(.WIDTH(12), .SEGS(3)) if3 ();
    segmented_register_if #(.WIDTH(16), .SEGS(4)) if4 ();

    segmented_register #(.WIDTH(16), .SEGS(2)) u_dut2 (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(if2));
    segmented_register #(.WIDTH(12), .SEGS(3)) u_dut3 (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(if3));
    segmented_register #(.WIDTH(16), .SEGS(4)) u_dut4 (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(if4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [3:0] d);
        if4.i_seq_valid = 1'b1;
        if4.i_seq_data  = d;
        tick();
        if4.i_seq_valid = 1'b0;
    endtask

    logic [4:0] seq_vec [5];

    initial begin
        if2.i_load_enable = '0; if2.i_load_src_sel = '0; if2.i_load_data = '0;
        if2.i_inc = 1'b0; if2.i_dec = 1'b0; if2.i_seq_start = 1'b0; if2.i_seq_valid = 1'b0; if2.i_seq_data = '0;
        if3.i_load_enable = '0; if3.i_load_src_sel = '0; if3.i_load_data = '0;
        if3.i_inc = 1'b0; if3.i_dec = 1'b0; if3.i_seq_start = 1'b0; if3.i_seq_valid = 1'b0; if3.i_seq_data = '0;
        if4.i_load_enable = '0; if4.i_load_src_sel = '0; if4.i_load_data = '0;
        if4.i_inc = 1'b0; if4.i_dec = 1'b0; if4.i_seq_start = 1'b0; if4.i_seq_valid = 1'b0; if4.i_seq_data = '0;
        rst = 1'b1;
        clk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_data4", 32'(if4.o_data), 32'h0);
        check("rst_busy4", 32'(if4.o_seq_busy), 32'h0);
        check("rst_done4", 32'(if4.o_seq_done), 32'h0);
        check("rst_wrap4", 32'(if4.o_wrap), 32'h0);
        check("rst_data2", 32'(if2.o_data), 32'h0);
        check("rst_data3", 32'(if3.o_data), 32'h0);

        // Parallel load, 16/2: replicate low byte, then partial load, then swapped lanes.
        if2.i_load_enable = 2'b11; if2.i_load_src_sel = 2'b00; if2.i_load_data = 16'hAB5C;
        tick();
        check("par_replicate", 32'(if2.o_data), 32'h5C5C);
        if2.i_load_enable = 2'b01; if2.i_load_src_sel = 2'b10; if2.i_load_data = 16'h1234;
        tick();
        check("par_low_only", 32'(if2.o_data), 32'h5C34);
        if2.i_load_enable = 2'b11; if2.i_load_src_sel = 2'b01; if2.i_load_data = 16'hA1B2;
        tick();
        check("par_swap", 32'(if2.o_data), 32'hB2A1);
        if2.i_load_enable = 2'b00;

        // 12/3: seg0<-lane1, seg1 select 3 (out of range -> own lane), seg2<-lane0.
        if3.i_load_enable = 3'b111; if3.i_load_src_sel = 6'b00_11_01; if3.i_load_data = 12'h5A7;
        tick();
        check("par_sel_oor", 32'(if3.o_data), 32'h7AA);
        if3.i_load_enable = 3'b000;

        // Sequential load, 16/4: beats D, stall, E, A, F.
        if4.i_seq_start = 1'b1;
        tick();
        if4.i_seq_start = 1'b0;
        busy_cnt = int'(if4.o_seq_busy);
        done_cnt = int'(if4.o_seq_done);
        seq_vec = '{5'h1D, 5'h07, 5'h1E, 5'h1A, 5'h1F};
        for (int i = 0; i < 5; i++) begin
            if4.i_seq_valid = seq_vec[i][4];
            if4.i_seq_data  = seq_vec[i][3:0];
            tick();
            busy_cnt += int'(if4.o_seq_busy);
            done_cnt += int'(if4.o_seq_done);
        end
        if4.i_seq_valid = 1'b0;
        check("seq_data", 32'(if4.o_data), 32'hFAED);
        check("seq_done_pulse", 32'(if4.o_seq_done), 32'h1);
        check("seq_busy_end", 32'(if4.o_seq_busy), 32'h0);
        tick();
        busy_cnt += int'(if4.o_seq_busy);
        done_cnt += int'(if4.o_seq_done);
        check("seq_done_clear", 32'(if4.o_seq_done), 32'h0);
        check("seq_busy_cycles", 32'(busy_cnt), 32'd5);
        check("seq_done_count", 32'(done_cnt), 32'd1);

        // Inc/dec with wrap; a same-cycle parallel load suppresses the inc.
        if4.i_load_enable = 4'hF; if4.i_load_src_sel = 8'b11_10_01_00; if4.i_load_data = 16'hFFFF;
        if4.i_inc = 1'b1;
        tick();
        if4.i_load_enable = 4'h0;
        check("load_over_inc", 32'(if4.o_data), 32'hFFFF);
        check("load_no_wrap", 32'(if4.o_wrap), 32'h0);
        tick();
        check("inc_wrap_data", 32'(if4.o_data), 32'h0);
        check("inc_wrap_flag", 32'(if4.o_wrap), 32'h1);
        if4.i_inc = 1'b0;
        tick();
        check("idle_wrap_clr", 32'(if4.o_wrap), 32'h0);
        check("idle_hold", 32'(if4.o_data), 32'h0);
        if4.i_dec = 1'b1;
        tick();
        check("dec_wrap_data", 32'(if4.o_data), 32'hFFFF);
        check("dec_wrap_flag", 32'(if4.o_wrap), 32'h1);
        if4.i_inc = 1'b1;
        tick();
        check("incdec_data", 32'(if4.o_data), 32'hFFFF);
        check("incdec_wrap", 32'(if4.o_wrap), 32'h0);
        if4.i_dec = 1'b0;

        // Start a sequence while incrementing, then freeze with clk_en low.
        if4.i_seq_start = 1'b1;
        tick();
        if4.i_seq_start = 1'b0;
        check("start_inc_data", 32'(if4.o_data), 32'h0);
        check("start_inc_wrap", 32'(if4.o_wrap), 32'h1);
        check("start_busy", 32'(if4.o_seq_busy), 32'h1);
        clk_en = 1'b0;
        if4.i_load_enable = 4'hF; if4.i_load_data = 16'h1234;
        if4.i_seq_valid = 1'b1; if4.i_seq_data = 4'h9;
        repeat (3) tick();
        check("hold_data", 32'(if4.o_data), 32'h0);
        check("hold_wrap", 32'(if4.o_wrap), 32'h1);
        check("hold_busy", 32'(if4.o_seq_busy), 32'h1);
        check("hold_done", 32'(if4.o_seq_done), 32'h0);
        clk_en = 1'b1;
        if4.i_load_enable = 4'h0; if4.i_inc = 1'b0; if4.i_seq_valid = 1'b0;
        beat(4'h1); beat(4'h2); beat(4'h3); beat(4'h4);
        check("hold_ptr_data", 32'(if4.o_data), 32'h4321);
        check("hold_ptr_done", 32'(if4.o_seq_done), 32'h1);

        // Reset while clk_en is low still clears.
        clk_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clk_en = 1'b1;
        check("rst_noen_data", 32'(if4.o_data), 32'h0);
        check("rst_noen_done", 32'(if4.o_seq_done), 32'h0);
        check("rst_noen_busy", 32'(if4.o_seq_busy), 32'h0);

        // Start with valid is start only; abort mid-sequence; restart from segment 0.
        if4.i_seq_start = 1'b1; if4.i_seq_valid = 1'b1; if4.i_seq_data = 4'h5;
        tick();
        if4.i_seq_start = 1'b0; if4.i_seq_valid = 1'b0;
        check("start_valid_busy", 32'(if4.o_seq_busy), 32'h1);
        beat(4'h6); beat(4'h7);
        check("partial_data", 32'(if4.o_data), 32'h0076);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_data", 32'(if4.o_data), 32'h0);
        check("abort_busy", 32'(if4.o_seq_busy), 32'h0);
        if4.i_seq_start = 1'b1;
        tick();
        if4.i_seq_start = 1'b0;
        beat(4'h8); beat(4'h9); beat(4'hA); beat(4'hB);
        check("restart_data", 32'(if4.o_data), 32'hBA98);
        check("restart_done", 32'(if4.o_seq_done), 32'h1);

        // Conflict: parallel load of the pointed segment wins, pointer still advances, inc ignored.
        if4.i_seq_start = 1'b1;
        tick();
        if4.i_seq_start = 1'b0;
        beat(4'h1);
        if4.i_seq_valid = 1'b1; if4.i_seq_data = 4'h3;
        if4.i_load_enable = 4'b0010; if4.i_load_src_sel = 8'b11_10_01_00; if4.i_load_data = 16'h00C0;
        if4.i_inc = 1'b1;
        tick();
        if4.i_seq_valid = 1'b0; if4.i_load_enable = 4'h0;
        check("conflict_data", 32'(if4.o_data), 32'hBAC1);
        check("conflict_wrap", 32'(if4.o_wrap), 32'h0);
        tick();
        if4.i_inc = 1'b0;
        check("load_state_inc", 32'(if4.o_data), 32'hBAC2);
        check("load_state_busy", 32'(if4.o_seq_busy), 32'h1);
        beat(4'h4); beat(4'h5);
        check("conflict_ptr_data", 32'(if4.o_data), 32'h54C2);
        check("conflict_ptr_done", 32'(if4.o_seq_done), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
